elevator_car_ctrl: RTL
======================

// Module: elevator_car_ctrl
// PURPOSE
//  Per-car motion/door controller. Sits downstream of the call handler: consumes its per-car
//  target-floor requests and produces the car location and E_states state the handler reads back
//  (E1_location/E1_state, E2_location/E2_state). One instance per car. Models floor travel and door
//  dwell with cycle counters; serves stops in the current direction before reversing (collective).
// PARAMETERS
//  NUM_FLOORS   6   floors served, 2..8 (location is 3 bits)
//  FLOOR_TICKS  8   clk cycles to travel one floor, >=1
//  DOOR_TICKS   4   clk cycles door stays open per stop, >=1
// PORTS
//  clk              in   1           clock
//  rst_n            in   1           reset, asynchronous, active-low
//  stop_req         in   NUM_FLOORS  target-floor bitmap from call handler (bit i = floor i)
//  stop_req_valid   in   1           qualifies stop_req; bits OR'ed into pending that cycle
//  location         out  3           current floor, binary
//  state            out  E_states    IDLE / MOVE_UP / MOVE_DOWN / SERVE (sys_pkg)
//  door_open        out  1           high exactly while state==SERVE
//  arrived          out  1           1-cycle pulse on entry to SERVE
//  pending          out  NUM_FLOORS  outstanding stops (for handler/debug)
//  door_hold        in   1           only with ELEV_DOOR_HOLD_EN
// BEHAVIOUR
//  Reset: location=0, state=IDLE, door_open=0, arrived=0, pending=0, timers=0, last_dir=UP.
//   Reset mid-move/mid-serve returns all to reset values immediately; no request retained.
//  Pending: pending_nxt = (pending | (stop_req_valid ? stop_req : 0)) & ~clr; clr = onehot(location)
//   on the cycle SERVE is entered and every cycle in SERVE (request for current floor while door open
//   is absorbed and reloads door timer to DOOR_TICKS). Bits for other floors always latch.
//  above = |pending[N-1:location+1]; below = |pending[location-1:0]; here = pending[location].
//  IDLE (decision each cycle, latency 1 cycle from request to state change):
//   here -> SERVE; else above&&(!below||last_dir==UP) -> MOVE_UP; else below -> MOVE_DOWN; else IDLE.
//  MOVE_UP/MOVE_DOWN: timer counts 0..FLOOR_TICKS-1; on terminal count location +/-1 (same edge) and
//   re-evaluate at the new floor: here -> SERVE; else continue if stops remain in same direction;
//   else reverse if stops opposite; else IDLE. last_dir updated on every move entry.
//   Location never passes 0 or NUM_FLOORS-1; state change happens only at floor boundaries.
//  SERVE: door_open=1, timer counts DOOR_TICKS cycles; on expiry: continue last_dir if stops that way,
//   else reverse, else IDLE. arrived pulses only on entry cycle.
//  Simultaneous: request arriving on same edge as terminal count is included in that re-evaluation
//   (uses pending_nxt). Request for floor being passed after terminal count is served on return.
//  state/location/door_open/arrived are registered outputs.
// CONFIGURATION
//  ELEV_DOOR_HOLD_EN defined: door_hold port present; while door_hold=1 in SERVE door timer is held at
//   reload, SERVE persists; exit DOOR_TICKS cycles after door_hold deasserts.
//  Not defined: no door_hold port; SERVE lasts exactly DOOR_TICKS cycles (plus reloads).
// TESTING
//  1 reset, idle at 0, stop_req=6'b001000 pulse -> MOVE_UP next cycle, location 1,2,3 at 8-cycle
//    steps, SERVE at 3, arrived 1 cycle, door_open 4 cycles, then IDLE, pending=0.
//  2 car at 3 MOVE_UP to 5, mid-travel request floor 1 -> serve 4?no: serve 5, then MOVE_DOWN to 1.
//  3 request current floor while IDLE -> SERVE next cycle, no movement; repeat in SERVE -> door
//    timer reloads (door_open extends to 4 cycles after last request).
//  4 IDLE at 2, simultaneous stops 0 and 5 with last_dir=UP -> goes up to 5 first, then 0.
//  5 assert rst_n=0 during MOVE_DOWN at floor 4 -> immediate location=0, IDLE, pending=0.
//  6 ELEV_DOOR_HOLD_EN: door_hold high 20 cycles in SERVE -> door_open held, exits 4 cycles after release.

Source files
------------

// File: rtl/elevator_car_ctrl.sv
// Per-car motion/door controller: collective up/down service with cycle-counted travel and door dwell.
// Optional door_hold input is enabled by defining ELEV_DOOR_HOLD_EN.
package sys_pkg;
    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, SERVE} E_states;
endpackage

module elevator_car_ctrl
    import sys_pkg::*;
#(
    parameter int NUM_FLOORS  = 6,
    parameter int FLOOR_TICKS = 8,
    parameter int DOOR_TICKS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] stop_req,
    input  logic                  stop_req_valid,
`ifdef ELEV_DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    output logic [2:0]            location,
    output E_states               state,
    output logic                  door_open,
    output logic                  arrived,
    output logic [NUM_FLOORS-1:0] pending
);
    localparam int TMAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] FLOOR_LAST = TW'(FLOOR_TICKS - 1);
    localparam logic [TW-1:0] DOOR_LAST  = TW'(DOOR_TICKS - 1);

    E_states               state_nxt;
    logic [2:0]            loc_nxt;
    logic [TW-1:0]         timer, timer_nxt;
    logic                  last_up, last_up_nxt;
    logic [NUM_FLOORS-1:0] pend_raw, pend_nxt;
    logic [NUM_FLOORS-1:0] above_m, below_m, here_m;
    logic                  above, below, here, move_done, decide, hold;
    logic                  arrived_nxt, door_nxt;

`ifdef ELEV_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    // State register (plus datapath and registered outputs)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            location  <= 3'd0;
            timer     <= '0;
            last_up   <= 1'b1;
            pending   <= '0;
            door_open <= 1'b0;
            arrived   <= 1'b0;
        end else begin
            state     <= state_nxt;
            location  <= loc_nxt;
            timer     <= timer_nxt;
            last_up   <= last_up_nxt;
            pending   <= pend_nxt;
            door_open <= door_nxt;
            arrived   <= arrived_nxt;
        end
    end

    // Direction masks are taken at the floor the car will be at after this edge,
    // so a terminal-count step re-evaluates at the new floor.
    always_comb begin
        move_done = (state == MOVE_UP || state == MOVE_DOWN) && (timer == FLOOR_LAST);
        loc_nxt   = location;
        if (move_done)
            loc_nxt = (state == MOVE_UP) ? location + 3'd1 : location - 3'd1;
        above_m = '0;
        below_m = '0;
        here_m  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above_m[i] = (i > int'(loc_nxt));
            below_m[i] = (i < int'(loc_nxt));
            here_m[i]  = (i == int'(loc_nxt));
        end
        pend_raw = pending | (stop_req_valid ? stop_req : '0);
        above    = |(pend_raw & above_m);
        below    = |(pend_raw & below_m);
        here     = |(pend_raw & here_m);
    end

    // Next-state logic
    always_comb begin
        state_nxt   = state;
        timer_nxt   = '0;
        last_up_nxt = last_up;
        decide      = 1'b0;
        unique case (state)
            IDLE:              decide = 1'b1;
            MOVE_UP, MOVE_DOWN: begin
                if (move_done) decide = 1'b1;
                else           timer_nxt = timer + 1'b1;
            end
            SERVE: begin
                if (here || hold)            timer_nxt = '0;
                else if (timer == DOOR_LAST) decide = 1'b1;
                else                         timer_nxt = timer + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        // Collective rule: keep the last direction while stops remain that way.
        if (decide) begin
            if (here) begin
                state_nxt = SERVE;
            end else if (above && (!below || last_up)) begin
                state_nxt   = MOVE_UP;
                last_up_nxt = 1'b1;
            end else if (below) begin
                state_nxt   = MOVE_DOWN;
                last_up_nxt = 1'b0;
            end else begin
                state_nxt = IDLE;
            end
        end
        pend_nxt = pend_raw & ~((state_nxt == SERVE) ? here_m : '0);
    end

    // Output logic
    always_comb begin
        door_nxt    = (state_nxt == SERVE);
        arrived_nxt = (state_nxt == SERVE) && (state != SERVE);
    end
endmodule
